// File: rtl/seq_mul_radix16.sv
// Sequential 32x32 multiplier. It retires one radix-16 multiplier digit per cycle.
// Signed operands are handled as magnitudes, with a conditional negate in the final cycle.
module seq_mul_radix16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [63:0] p;
  logic [31:0] mag_a;
  logic        neg;

  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;
  logic [3:0]  d;
  logic [35:0] pp;
  logic [35:0] sum;
  logic [63:0] result;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  always_comb begin
    mag_a_in = (is_signed & a[31]) ? (~a + 32'd1) : a;
    mag_b_in = (is_signed & b[31]) ? (~b + 32'd1) : b;
  end

  always_comb begin
    d   = p[3:0];
    pp  = (d[0] ? {4'b0000, mag_a}        : '0)
        + (d[1] ? {3'b000, mag_a, 1'b0}   : '0)
        + (d[2] ? {2'b00, mag_a, 2'b00}   : '0)
        + (d[3] ? {1'b0, mag_a, 3'b000}   : '0);
    sum    = {4'b0000, p[63:32]} + pp;
    result = neg ? (~p + 64'd1) : p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      p     <= '0;
      mag_a <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_a <= mag_a_in;
            neg   <= is_signed & (a[31] ^ b[31]);
            p     <= {32'h0000_0000, mag_b_in};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          p   <= {sum, p[31:4]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= FIX;
        end
        FIX: begin
          hi    <= result[63:32];
          lo    <= result[31:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_radix16.sv
// Directed and small randomized checks of seq_mul_radix16. The bench checks results, latency, the handshake and reset.
module tb_seq_mul_radix16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned checks;
  int unsigned errors;

  seq_mul_radix16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge. Start is sampled on the next edge.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic [63:0] exp, input string tag);
    int unsigned lat;
    int unsigned busy_cnt;
    logic        hold_ok;
    logic        overlap;
    logic [63:0] prev;
    prev      = {hi, lo};
    a         = ta;
    b         = tb;
    is_signed = ts;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    a        = ~ta;
    b        = ~tb;
    lat      = 0;
    busy_cnt = 0;
    hold_ok  = 1'b1;
    overlap  = 1'b0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      if ({hi, lo} !== prev) hold_ok = 1'b0;
      tick();
      lat++;
    end
    if (busy && done) overlap = 1'b1;
    check({tag, "_lat"},  64'(lat), 64'd9);
    check({tag, "_busy"}, 64'(busy_cnt), 64'd9);
    check({tag, "_hold"}, {63'd0, hold_ok}, 64'd1);
    check({tag, "_ovl"},  {63'd0, overlap}, 64'd0);
    check({tag, "_res"},  {hi, lo}, exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] rexp;
    logic        seen_done;
    int unsigned rlat;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    tick();
    tick();

    run_op(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, "u_basic");
    tick();
    check("done_pulse", {63'd0, done}, 64'd0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_max");
    run_op(32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, "u_msb");
    run_op(32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, "s_mix");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "s_m1m1");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_min");
    run_op(32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "s_pn");
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, "u_mid");
    tick();

    // Start pulses during the busy period are ignored
    a = 32'd3; b = 32'd5; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    seen_done = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 2 || k == 6) begin
        start = 1'b1; a = 32'd100; b = 32'd100;
      end else begin
        start = 1'b0;
      end
      tick();
      if (k < 9 && done) seen_done = 1'b1;
    end
    start = 1'b0;
    check("hs_early", {63'd0, seen_done}, 64'd0);
    check("hs_done",  {63'd0, done}, 64'd1);
    check("hs_res",   {hi, lo}, 64'h0000_0000_0000_000F);
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check("hs_single", {63'd0, seen_done}, 64'd0);

    // Start in the done cycle is accepted; run_op checks that hi/lo hold until then
    run_op(32'd10, 32'd20, 1'b0, 64'd200, "b2b_1");
    run_op(32'd11, 32'd13, 1'b0, 64'd143, "b2b_2");

    // Asynchronous reset during CALC
    a = 32'd9; b = 32'd9; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy", {63'd0, busy}, 64'd0);
    check("ar_done", {63'd0, done}, 64'd0);
    check("ar_hilo", {hi, lo}, 64'd0);
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    check("ar_quiet", {63'd0, seen_done}, 64'd0);
    run_op(32'd12, 32'd12, 1'b0, 64'd144, "ar_after");

    // Randomized operands with random gaps, checked against a 64-bit reference
    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(1, 0));
      if (n % 16 == 0) ra = 32'h8000_0000;
      if (n % 16 == 1) rb = 32'hFFFF_FFFF;
      if (rs) rexp = 64'(longint'($signed(ra)) * longint'($signed(rb)));
      else    rexp = {32'd0, ra} * {32'd0, rb};
      run_op(ra, rb, rs, rexp, "rnd");
      rlat = $urandom_range(3, 0);
      for (int g = 0; g < int'(rlat); g++) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
